wptr_handler: RTL and testbench
===============================

# wptr_handler

Write-side pointer and status block of the asynchronous FIFO, the write-domain counterpart of the read-pointer logic. It keeps the binary and Gray write pointers and drives the RAM write address. It compares its next Gray pointer against the read pointer, already synchronized into the write domain, to produce registered `full`, `almost_full`, fill level and a sticky overflow flag. The Gray write pointer it outputs feeds the write-to-read synchronizer.

## Interface
Parameters:
- `ADDR_W`, default 4: RAM address width; depth = 2^ADDR_W; pointers are ADDR_W+1 bits.
- `AFULL_THRESH`, default 12: fill level at or above which `almost_full` asserts; legal range 1..2^ADDR_W.

Ports:
- `wclk` in 1: write clock; the only clock.
- `wrst` in 1: synchronous, active-high reset.
- `w_en` in 1: write request.
- `g_rptr` in ADDR_W+1: Gray read pointer, synchronized into the wclk domain.
- `ovf_clr` in 1: clears `overflow`.
- `waddr` out ADDR_W: RAM write address, equal to `wbin[ADDR_W-1:0]`.
- `wptr` out ADDR_W+1: registered Gray write pointer, sent to the synchronizer.
- `w_ack` out 1: combinational; `w_en & ~full`; RAM write strobe.
- `full` out 1: registered full flag.
- `almost_full` out 1: registered; fill level ≥ AFULL_THRESH.
- `wlevel` out ADDR_W+1: registered fill level, range 0..2^ADDR_W.
- `overflow` out 1: sticky; set when a write is attempted while full.

## Operation
- State registers: `wbin` and `wptr` (ADDR_W+1 each), `full`, `almost_full`, `wlevel`, `overflow`.
- `wbin_next = wbin + w_ack`. The sum is modulo 2^(ADDR_W+1), so the extra MSB toggles on each lap.
- `g_wptr_next = wbin_next ^ (wbin_next >> 1)`.
- Full compare:
  - `full_next = (g_wptr_next == {~g_rptr[ADDR_W:ADDR_W-1], g_rptr[ADDR_W-2:0]})`.
  - For ADDR_W = 1, invert both bits.
- Level:
  - `rbin_sync = gray2bin(g_rptr)`.
  - `level_next = wbin_next - rbin_sync`, modulo 2^(ADDR_W+1).
  - `almost_full_next = (level_next >= AFULL_THRESH)`.
- Overflow:
  - Set when `w_en & full`.
  - Clear when `ovf_clr`; set wins if both occur in the same cycle.
  - Otherwise hold.
- Write while `full` is ignored: pointers, `waddr` and `wlevel` hold, and `w_ack` = 0.
- Reset values when `wrst` = 1 at a wclk edge:
  - `wbin` = 0, `wptr` = 0, `waddr` = 0.
  - `full` = 0, `almost_full` = 0, `wlevel` = 0, `overflow` = 0.
  - `w_ack` = 0 during reset, regardless of `w_en`.
- Reset mid-operation discards all outstanding state. The read side must be reset in the same window; the block provides no cross-domain coordination.

## Timing
- `waddr`, `wptr`, `full`, `almost_full` and `wlevel` all update at the same wclk edge that commits a write.
- `full`, `almost_full` and `wlevel` are computed from next-state values, so they are valid in the cycle right after the write that causes them. There is no extra lag.
- Example: the write that makes the FIFO full has `full` = 1 on the next cycle, so a write issued in that cycle is blocked.
- Flags are pessimistic. `full` and `wlevel` reflect reads only after the external synchronizer delay, nominally 2 wclk edges after `g_rptr` changes in the rclk domain. `full` may stay high while entries are already free; it never deasserts early.
- If `g_rptr` changes in the same cycle as `w_en`, both take effect in `full_next` and `level_next`.
- `w_ack` has zero latency from `w_en`. The RAM samples `waddr` and data on the same edge that advances `wbin`.

## Structure
- Shared package `fifo_pkg`:
  - Default `ADDR_W`.
  - Pointer width constant `PTR_W = ADDR_W+1`.
  - Functions `bin2gray` and `gray2bin`.
- Reuse existing `b2g` for `g_wptr_next`.
- Add one sub-module, `g2b` (combinational Gray-to-binary, PTR_W bits), for `rbin_sync`. Verify `g2b(b2g(x)) == x` exhaustively in its own unit test.

## Test plan
All scenarios use ADDR_W = 4 and AFULL_THRESH = 12.
- **Reset:** hold `wrst` for 3 cycles with `w_en` = 1 → all outputs 0 and `w_ack` = 0; the first write after release goes to `waddr` 0 and gives `wptr` = 5'b00001.
- **Fill from empty** (`g_rptr` = 0, `w_en` held):
  - `waddr` steps 0..15.
  - `almost_full` is 1 on the cycle after the 12th write.
  - `full` = 1 and `wlevel` = 16 on the cycle after the 16th write.
  - The 17th attempt gives `w_ack` = 0 and `waddr` holds 0.
  - `overflow` = 1 the next cycle and stays 1 until `ovf_clr`.
- **Drain while full:** drive `g_rptr` = b2g(4) → on the next cycle `full` = 0 and `wlevel` = 12; then 4 writes → `full` = 1 again with `wbin` = 5'b10100.
- **Wrap:** keep `g_rptr` trailing by 3 and write 40 times → `waddr` wraps 15→0 twice; `wptr` changes exactly one bit per write; `full` never asserts; `wlevel` stays 3 or 4.
- **Simultaneous events:**
  - At full, with `w_en` = 1 in the same cycle `g_rptr` advances by 1 → that write is blocked (`full` still 1); `full` = 0 the next cycle.
  - `ovf_clr` coinciding with a blocked write → `overflow` stays 1.
- **Mid-operation reset:** after 7 writes, assert `wrst` for 1 cycle → `wbin`, `wptr`, `wlevel` and all flags return to 0 on the next cycle.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared async-FIFO definitions: default geometry and Gray/binary pointer helpers.
package fifo_pkg;

    localparam int unsigned DEF_ADDR_W = 4;
    localparam int unsigned DEF_PTR_W  = DEF_ADDR_W + 1;

    function automatic logic [DEF_PTR_W-1:0] bin2gray(input logic [DEF_PTR_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic logic [DEF_PTR_W-1:0] gray2bin(input logic [DEF_PTR_W-1:0] gray);
        logic [DEF_PTR_W-1:0] bin;
        for (int i = 0; i < int'(DEF_PTR_W); i++) begin
            bin[i] = ^(gray >> i);
        end
        return bin;
    endfunction

endpackage

// File: rtl/b2g.sv
// Combinational binary-to-Gray converter.
module b2g #(
    parameter int unsigned W = 5
) (
    input  logic [W-1:0] bin,
    output logic [W-1:0] gray
);

    assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/g2b.sv
// Combinational Gray-to-binary converter: each bin bit is the XOR of all Gray bits at or above it.
module g2b #(
    parameter int unsigned W = 5
) (
    input  logic [W-1:0] gray,
    output logic [W-1:0] bin
);

    always_comb begin
        bin = '0;
        for (int i = 0; i < int'(W); i++) begin
            bin[i] = ^(gray >> i);
        end
    end

endmodule

// File: rtl/wptr_handler.sv
// Write-side pointer and status logic of the async FIFO: binary/Gray write pointers,
// RAM write address, and registered full / almost_full / level / sticky overflow.
module wptr_handler
    import fifo_pkg::*;
#(
    parameter int unsigned ADDR_W       = DEF_ADDR_W,
    parameter int unsigned AFULL_THRESH = 12
) (
    input  logic              wclk,
    input  logic              wrst,
    input  logic              w_en,
    input  logic [ADDR_W:0]   g_rptr,
    input  logic              ovf_clr,
    output logic [ADDR_W-1:0] waddr,
    output logic [ADDR_W:0]   wptr,
    output logic              w_ack,
    output logic              full,
    output logic              almost_full,
    output logic [ADDR_W:0]   wlevel,
    output logic              overflow
);

    localparam int unsigned PTR_W = ADDR_W + 1;
    // Full when the write pointer is one lap ahead: top two Gray bits inverted.
    localparam logic [PTR_W-1:0] FULL_MASK = PTR_W'(3) << (PTR_W - 2);

    logic [PTR_W-1:0] wbin;
    logic [PTR_W-1:0] wbin_next;
    logic [PTR_W-1:0] g_wptr_next;
    logic [PTR_W-1:0] rbin_sync;
    logic [PTR_W-1:0] level_next;
    logic             full_next;
    logic             almost_full_next;

    assign w_ack = w_en & ~full & ~wrst;
    assign waddr = wbin[ADDR_W-1:0];

    b2g #(.W(PTR_W)) u_b2g (
        .bin  (wbin_next),
        .gray (g_wptr_next)
    );

    g2b #(.W(PTR_W)) u_g2b (
        .gray (g_rptr),
        .bin  (rbin_sync)
    );

    always_comb begin
        wbin_next        = wbin + PTR_W'(w_ack);
        full_next        = (g_wptr_next == (g_rptr ^ FULL_MASK));
        level_next       = wbin_next - rbin_sync;
        almost_full_next = (level_next >= PTR_W'(AFULL_THRESH));
    end

    // Pointer and status registers; a blocked write leaves everything but overflow unchanged.
    always_ff @(posedge wclk) begin
        if (wrst) begin
            wbin        <= '0;
            wptr        <= '0;
            full        <= 1'b0;
            almost_full <= 1'b0;
            wlevel      <= '0;
            overflow    <= 1'b0;
        end else begin
            wbin        <= wbin_next;
            wptr        <= g_wptr_next;
            full        <= full_next;
            almost_full <= almost_full_next;
            wlevel      <= level_next;
            if (w_en && full) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_wptr_handler.sv
// Self-checking bench for wptr_handler: directed scenarios plus random traffic
// compared every cycle against a write/read-count model of the FIFO.
module tb_wptr_handler;

    logic       wclk = 1'b0;
    logic       wrst = 1'b1;
    logic       w_en = 1'b0;
    logic [4:0] g_rptr = '0;
    logic       ovf_clr = 1'b0;
    logic [3:0] waddr;
    logic [4:0] wptr;
    logic       w_ack;
    logic       full;
    logic       almost_full;
    logic [4:0] wlevel;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    // Model state: counts of writes/reads modulo 32 and derived flags
    int m_wr = 0;
    int rd_cnt = 0;
    int m_lvl = 0;
    bit m_full = 0;
    bit m_af = 0;
    bit m_ovf = 0;
    bit started = 0;

    always #5 wclk = ~wclk;

    wptr_handler #(.ADDR_W(4), .AFULL_THRESH(12)) dut (
        .wclk        (wclk),
        .wrst        (wrst),
        .w_en        (w_en),
        .g_rptr      (g_rptr),
        .ovf_clr     (ovf_clr),
        .waddr       (waddr),
        .wptr        (wptr),
        .w_ack       (w_ack),
        .full        (full),
        .almost_full (almost_full),
        .wlevel      (wlevel),
        .overflow    (overflow)
    );

    function automatic logic [4:0] gray5(input int v);
        logic [4:0] b;
        b = 5'(v);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge wclk);
        #1;
    endtask

    task automatic set_rd(input int v);
        rd_cnt = v & 31;
        g_rptr = gray5(rd_cnt);
    endtask

    // Reference model: a FIFO holds (writes - reads) entries; it is full at 16.
    always @(posedge wclk) begin
        if (wrst) begin
            m_wr = 0; m_lvl = 0; m_full = 0; m_af = 0; m_ovf = 0;
        end else begin
            if (w_en && m_full) m_ovf = 1;
            else if (ovf_clr) m_ovf = 0;
            if (w_en && !m_full) m_wr = (m_wr + 1) % 32;
            m_lvl  = (m_wr - rd_cnt + 32) % 32;
            m_full = (m_lvl == 16);
            m_af   = (m_lvl >= 12);
        end
        started = 1;
    end

    // Cycle-by-cycle comparison against the model, away from the active edge
    always @(negedge wclk) begin
        if (started) begin
            chk("waddr",       32'(waddr),       32'(m_wr % 16));
            chk("wptr",        32'(wptr),        32'(gray5(m_wr)));
            chk("full",        32'(full),        32'(m_full));
            chk("almost_full", 32'(almost_full), 32'(m_af));
            chk("wlevel",      32'(wlevel),      32'(m_lvl));
            chk("overflow",    32'(overflow),    32'(m_ovf));
            chk("w_ack",       32'(w_ack),       32'(w_en && !m_full && !wrst));
        end
    end

    initial begin
        logic [4:0] prev_ptr;
        logic [3:0] prev_addr;
        int wraps;

        // Gray helper round trip over the whole pointer space
        for (int x = 0; x < 32; x++) begin
            chk("pkg_bin2gray", 32'(fifo_pkg::bin2gray(5'(x))), 32'(gray5(x)));
            chk("pkg_roundtrip", 32'(fifo_pkg::gray2bin(fifo_pkg::bin2gray(5'(x)))), 32'(x));
        end

        // Reset held 3 cycles with w_en high
        wrst = 1; w_en = 1; set_rd(0);
        repeat (3) tick();
        chk("rst_w_ack", 32'(w_ack), 32'd0);
        chk("rst_wptr", 32'(wptr), 32'd0);
        chk("rst_wlevel", 32'(wlevel), 32'd0);
        wrst = 0;
        #0;
        chk("first_waddr", 32'(waddr), 32'd0);
        tick();
        chk("first_wptr", 32'(wptr), 32'b00001);

        // Fill from empty
        for (int i = 2; i <= 16; i++) begin
            tick();
            if (i == 11) chk("af_before_12", 32'(almost_full), 32'd0);
            if (i == 12) chk("af_at_12", 32'(almost_full), 32'd1);
        end
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_level", 32'(wlevel), 32'd16);
        #1;
        chk("blocked_w_ack", 32'(w_ack), 32'd0);
        tick();
        chk("blocked_waddr", 32'(waddr), 32'd0);
        chk("ovf_set", 32'(overflow), 32'd1);
        w_en = 0;
        tick();
        chk("ovf_sticky", 32'(overflow), 32'd1);
        w_en = 1; ovf_clr = 1;
        tick();
        chk("ovf_set_wins", 32'(overflow), 32'd1);
        w_en = 0;
        tick();
        chk("ovf_cleared", 32'(overflow), 32'd0);
        ovf_clr = 0;

        // Drain four entries while full, then refill
        set_rd(4);
        tick();
        chk("drain_full", 32'(full), 32'd0);
        chk("drain_level", 32'(wlevel), 32'd12);
        w_en = 1;
        repeat (4) tick();
        w_en = 0;
        chk("refill_full", 32'(full), 32'd1);
        chk("refill_wptr", 32'(wptr), 32'b11110);
        chk("refill_waddr", 32'(waddr), 32'd4);

        // Write at full while the read pointer advances in the same cycle
        w_en = 1; set_rd(5);
        #1;
        chk("simul_blocked", 32'(w_ack), 32'd0);
        tick();
        w_en = 0;
        chk("simul_full_clear", 32'(full), 32'd0);
        chk("simul_level", 32'(wlevel), 32'd15);
        chk("simul_waddr", 32'(waddr), 32'd4);

        // Wrap with the reader trailing by three
        set_rd(m_wr - 3);
        w_en = 1;
        wraps = 0;
        for (int i = 0; i < 40; i++) begin
            prev_ptr = wptr;
            prev_addr = waddr;
            tick();
            chk("wrap_onebit", 32'($countones(wptr ^ prev_ptr)), 32'd1);
            chk("wrap_level", 32'(wlevel == 5'd3 || wlevel == 5'd4), 32'd1);
            if (prev_addr == 4'd15 && waddr == 4'd0) wraps++;
            set_rd(m_wr - 3);
        end
        chk("wrap_count", 32'(wraps), 32'd2);
        w_en = 0;

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            w_en = ($urandom_range(0, 99) < 60);
            ovf_clr = ($urandom_range(0, 99) < 5);
            tick();
            if (rd_cnt != m_wr && $urandom_range(0, 2) == 0) set_rd(rd_cnt + 1);
        end
        w_en = 0; ovf_clr = 0;

        // Mid-operation reset after seven writes
        wrst = 1; set_rd(0);
        tick();
        wrst = 0; w_en = 1;
        repeat (7) tick();
        chk("pre_rst_waddr", 32'(waddr), 32'd7);
        wrst = 1; w_en = 0;
        tick();
        wrst = 0;
        chk("mid_rst_wptr", 32'(wptr), 32'd0);
        chk("mid_rst_waddr", 32'(waddr), 32'd0);
        chk("mid_rst_level", 32'(wlevel), 32'd0);
        chk("mid_rst_flags", 32'({full, almost_full, overflow}), 32'd0);
        repeat (2) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
